aes_inv_sub_bytes: RTL

Sequential InvSubBytes engine for the AES decryption datapath. It accepts a 128-bit cipher state over a valid/ready handshake and applies the AES inverse S-box to every byte, LANES bytes per cycle, using a shared combinational inverse S-box. It then holds the result under a valid/ready output handshake. It sits beside the forward SubBytes logic and feeds the InvShiftRows/AddRoundKey stages of the decrypt round.

---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_inv_sub_bytes_inv_sbox.sv | 30 +++
 rtl/aes_inv_sub_bytes.sv | 112 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath types and constants used by the decrypt-round stages.
package aes_pkg;

    localparam int AES_STATE_BYTES = 16;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } inv_sb_state_e;

endpackage

// File: rtl/aes_inv_sub_bytes_inv_sbox.sv
// Purely combinational AES inverse S-box; row r of the table holds entries 16r..16r+15.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// Sequential InvSubBytes engine: substitutes LANES bytes per cycle of a 128-bit
// state in place, with valid/ready handshakes on both sides.
module aes_inv_sub_bytes #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    import aes_pkg::*;

    localparam int STEPS = AES_STATE_BYTES / LANES;
    localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("aes_inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
    end

    inv_sb_state_e fsm_q, fsm_d;
    logic [IDX_W-1:0] idx_q;
    aes_state_t state_q, state_sub;
    logic load, step;

    aes_byte_t lane_in  [LANES];
    aes_byte_t lane_out [LANES];
    logic [3:0] lane_pos [LANES];

    // Each lane reads one byte of the current group and shares the write-back position.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_pos[i] = 4'(int'(idx_q) * LANES + i);
        assign lane_in[i]  = state_q[{lane_pos[i], 3'b000} +: 8];
        inv_sbox u_inv_sbox (
            .in_byte  (lane_in[i]),
            .out_byte (lane_out[i])
        );
    end

    always_comb begin
        state_sub = state_q;
        for (int i = 0; i < LANES; i++) begin
            state_sub[{lane_pos[i], 3'b000} +: 8] = lane_out[i];
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load  = 1'b1;
                    fsm_d = SUB;
                end
            end
            SUB: begin
                busy = 1'b1;
                step = 1'b1;
                if (idx_q == IDX_W'(STEPS - 1)) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                // Accepting the result and a new state in the same cycle avoids an idle bubble.
                if (out_ready) begin
                    if (in_valid) begin
                        load  = 1'b1;
                        fsm_d = SUB;
                    end else begin
                        fsm_d = IDLE;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
        if (rst) begin
            in_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            idx_q   <= '0;
            state_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            if (load) begin
                state_q <= in_state;
                idx_q   <= '0;
            end else if (step) begin
                state_q <= state_sub;
                idx_q   <= (idx_q == IDX_W'(STEPS - 1)) ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    assign out_state = state_q;

endmodule
